// File: rtl/ppu_pkg.sv
// Shared constants for the PPU fetch/decode front end: memory geometry,
// MIPS opcode/funct codes, control-word bit positions and field encodings.
package ppu_pkg;

    localparam int MEM_BYTES = 512;
    localparam int ADDR_W    = $clog2(MEM_BYTES);
    localparam int CTL_W     = 15;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int CTL_SHIFT_IMM    = 14;
    localparam int CTL_ALU_OP_MSB   = 13;
    localparam int CTL_ALU_OP_LSB   = 11;
    localparam int CTL_LOAD         = 10;
    localparam int CTL_RF_EN        = 9;
    localparam int CTL_BRANCH       = 8;
    localparam int CTL_TA_INSTR     = 7;
    localparam int CTL_MEM_SIZE_MSB = 6;
    localparam int CTL_MEM_SIZE_LSB = 5;
    localparam int CTL_MEM_RW       = 4;
    localparam int CTL_MEM_SE       = 3;
    localparam int CTL_HI_EN        = 2;
    localparam int CTL_LO_EN        = 1;
    localparam int CTL_MEM_EN       = 0;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

endpackage

// File: rtl/ppu_control_unit_if.sv
// Fetch address, instruction-memory preload port and the registered IF/ID outputs.
interface ppu_control_unit_if;
    import ppu_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic [31:0]       instruction;
    logic [CTL_W-1:0]  control_output;

    modport master (
        output addr, load_we, load_addr, load_data,
        input  instruction, control_output
    );

    modport slave (
        input  addr, load_we, load_addr, load_data,
        output instruction, control_output
    );

endinterface

// File: rtl/instruction_memory.sv
// Byte-addressed instruction store: synchronous byte write, combinational
// word-aligned big-endian 32-bit read.
module instruction_memory
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [7:0] mem_q [MEM_BYTES];

    // Preload writes are honoured regardless of reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads ignore the two low address bits, so a word never straddles the top.
    logic [1:0] unusedAddrLo;
    assign unusedAddrLo = raddr_i[1:0];

    assign rdata_o = {mem_q[{raddr_i[ADDR_W-1:2], 2'b00}],
                      mem_q[{raddr_i[ADDR_W-1:2], 2'b01}],
                      mem_q[{raddr_i[ADDR_W-1:2], 2'b10}],
                      mem_q[{raddr_i[ADDR_W-1:2], 2'b11}]};

endmodule

// File: rtl/ppu_control_unit.sv
// IF/ID front end: fetches a word from instruction memory, decodes it into the
// 15-bit pipeline control word and registers both.
module ppu_control_unit
    import ppu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ppu_control_unit_if.slave  bus
);

    logic [31:0]      instr_d;
    logic [31:0]      instr_q;
    logic [CTL_W-1:0] ctl_d;
    logic [CTL_W-1:0] ctl_q;

    instruction_memory u_imem (
        .clk     (clk),
        .we_i    (bus.load_we),
        .waddr_i (bus.load_addr),
        .wdata_i (bus.load_data),
        .raddr_i (bus.addr),
        .rdata_o (instr_d)
    );

    function automatic logic [CTL_W-1:0] decode(input logic [5:0] op, input logic [5:0] funct);
        logic [CTL_W-1:0] c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: begin
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_ADD;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    FN_SUB, FN_SUBU: begin
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_SUB;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    FN_AND: begin
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_AND;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    FN_OR: begin
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_OR;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    FN_XOR: begin
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_XOR;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    FN_NOR: begin
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_NOR;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    FN_SLT, FN_SLTU: begin
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_SLT;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    // Shifts take shamt as operand B, hence shift_imm.
                    FN_SLL, FN_SRL, FN_SRA: begin
                        c[CTL_SHIFT_IMM] = 1'b1;
                        c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_PASS;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: c[CTL_RF_EN] = 1'b1;
                    FN_MTHI:          c[CTL_HI_EN] = 1'b1;
                    FN_MTLO:          c[CTL_LO_EN] = 1'b1;
                    FN_JR:            c[CTL_BRANCH] = 1'b1;
                    FN_JALR: begin
                        c[CTL_BRANCH] = 1'b1;
                        c[CTL_RF_EN] = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                c[CTL_SHIFT_IMM] = 1'b1;
                c[CTL_RF_EN] = 1'b1;
                case (op)
                    OP_SLTI, OP_SLTIU: c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_SLT;
                    OP_ANDI:           c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_AND;
                    OP_ORI:            c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_OR;
                    OP_XORI:           c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_XOR;
                    OP_LUI:            c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_PASS;
                    default:           c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_ADD;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                c[CTL_SHIFT_IMM] = 1'b1;
                c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_ADD;
                c[CTL_LOAD] = 1'b1;
                c[CTL_RF_EN] = 1'b1;
                c[CTL_MEM_EN] = 1'b1;
                c[CTL_MEM_SE] = (op == OP_LB) || (op == OP_LH);
                case (op)
                    OP_LH, OP_LHU: c[CTL_MEM_SIZE_MSB:CTL_MEM_SIZE_LSB] = MEM_HALF;
                    OP_LW:         c[CTL_MEM_SIZE_MSB:CTL_MEM_SIZE_LSB] = MEM_WORD;
                    default:       c[CTL_MEM_SIZE_MSB:CTL_MEM_SIZE_LSB] = MEM_BYTE;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                c[CTL_SHIFT_IMM] = 1'b1;
                c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_ADD;
                c[CTL_MEM_RW] = 1'b1;
                c[CTL_MEM_EN] = 1'b1;
                case (op)
                    OP_SH:   c[CTL_MEM_SIZE_MSB:CTL_MEM_SIZE_LSB] = MEM_HALF;
                    OP_SW:   c[CTL_MEM_SIZE_MSB:CTL_MEM_SIZE_LSB] = MEM_WORD;
                    default: c[CTL_MEM_SIZE_MSB:CTL_MEM_SIZE_LSB] = MEM_BYTE;
                endcase
            end
            // Conditional branches compare via subtraction.
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                c[CTL_ALU_OP_MSB:CTL_ALU_OP_LSB] = ALU_SUB;
                c[CTL_BRANCH] = 1'b1;
            end
            OP_J: begin
                c[CTL_BRANCH] = 1'b1;
                c[CTL_TA_INSTR] = 1'b1;
            end
            OP_JAL: begin
                c[CTL_BRANCH] = 1'b1;
                c[CTL_TA_INSTR] = 1'b1;
                c[CTL_RF_EN] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // The all-zero word is architecturally SLL $0,$0,0; treat it as a true bubble.
    assign ctl_d = (instr_d == 32'h0) ? '0 : decode(instr_d[31:26], instr_d[5:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            ctl_q   <= '0;
        end else begin
            instr_q <= instr_d;
            ctl_q   <= ctl_d;
        end
    end

    assign bus.instruction    = instr_q;
    assign bus.control_output = ctl_q;

endmodule

// File: tb/tb_ppu_control_unit.sv
// Bench for ppu_control_unit: directed decode vectors, boundary sequences and
// random fetch/preload/reset traffic against a byte-array + lookup-table model.
module tb_ppu_control_unit;
   import ppu_pkg::*;

   logic clk = 1'b0;
   logic reset;

   ppu_control_unit_if bus();

   ppu_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model state: byte image of the memory plus opcode/funct lookup tables
   logic [7:0] refMem [512];
   int opTable [int];
   int functTable [int];

   localparam int SHIFT = 1 << 14;
   localparam int LOAD  = 1 << 10;
   localparam int RF    = 1 << 9;
   localparam int BR    = 1 << 8;
   localparam int TA    = 1 << 7;
   localparam int RW    = 1 << 4;
   localparam int SE    = 1 << 3;
   localparam int HI    = 1 << 2;
   localparam int LO    = 1 << 1;
   localparam int MEN   = 1;

   function automatic int alu(int n);
      return n * 2048;
   endfunction

   function automatic int size(int n);
      return n * 32;
   endfunction

   // Control words taken straight from the decode rules, one entry per instruction
   task automatic buildModel();
      functTable[32'h20] = alu(0) | RF;
      functTable[32'h21] = alu(0) | RF;
      functTable[32'h22] = alu(1) | RF;
      functTable[32'h23] = alu(1) | RF;
      functTable[32'h24] = alu(2) | RF;
      functTable[32'h25] = alu(3) | RF;
      functTable[32'h26] = alu(4) | RF;
      functTable[32'h27] = alu(5) | RF;
      functTable[32'h2A] = alu(6) | RF;
      functTable[32'h2B] = alu(6) | RF;
      functTable[32'h00] = SHIFT | alu(7) | RF;
      functTable[32'h02] = SHIFT | alu(7) | RF;
      functTable[32'h03] = SHIFT | alu(7) | RF;
      functTable[32'h10] = RF;
      functTable[32'h12] = RF;
      functTable[32'h11] = HI;
      functTable[32'h13] = LO;
      functTable[32'h08] = BR;
      functTable[32'h09] = BR | RF;
      opTable[32'h08] = SHIFT | alu(0) | RF;
      opTable[32'h09] = SHIFT | alu(0) | RF;
      opTable[32'h0A] = SHIFT | alu(6) | RF;
      opTable[32'h0B] = SHIFT | alu(6) | RF;
      opTable[32'h0C] = SHIFT | alu(2) | RF;
      opTable[32'h0D] = SHIFT | alu(3) | RF;
      opTable[32'h0E] = SHIFT | alu(4) | RF;
      opTable[32'h0F] = SHIFT | alu(7) | RF;
      opTable[32'h20] = SHIFT | LOAD | RF | MEN | size(0) | SE;
      opTable[32'h21] = SHIFT | LOAD | RF | MEN | size(1) | SE;
      opTable[32'h23] = SHIFT | LOAD | RF | MEN | size(2);
      opTable[32'h24] = SHIFT | LOAD | RF | MEN | size(0);
      opTable[32'h25] = SHIFT | LOAD | RF | MEN | size(1);
      opTable[32'h28] = SHIFT | RW | MEN | size(0);
      opTable[32'h29] = SHIFT | RW | MEN | size(1);
      opTable[32'h2B] = SHIFT | RW | MEN | size(2);
      opTable[32'h01] = alu(1) | BR;
      opTable[32'h04] = alu(1) | BR;
      opTable[32'h05] = alu(1) | BR;
      opTable[32'h06] = alu(1) | BR;
      opTable[32'h07] = alu(1) | BR;
      opTable[32'h02] = BR | TA;
      opTable[32'h03] = BR | TA | RF;
   endtask

   function automatic logic [14:0] refCtl(logic [31:0] w);
      int op;
      int fn;
      if (w == 32'h0) return 15'h0;
      op = int'(w >> 26);
      fn = int'(w & 32'h3F);
      if (op == 0) return functTable.exists(fn) ? 15'(functTable[fn]) : 15'h0;
      return opTable.exists(op) ? 15'(opTable[op]) : 15'h0;
   endfunction

   function automatic logic [31:0] refWord(int a);
      int b;
      b = a - (a % 4);
      return (32'(refMem[b]) << 24) | (32'(refMem[b + 1]) << 16) |
             (32'(refMem[b + 2]) << 8) | 32'(refMem[b + 3]);
   endfunction

   // Random instruction drawn mostly from the decodable set, with random operand fields
   function automatic logic [31:0] genInstr();
      int ops [24] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                       32, 33, 35, 36, 37, 63};
      int fns [21] = '{0, 2, 3, 8, 9, 16, 17, 18, 19, 32, 33, 34, 35, 36, 37, 38, 39,
                       42, 43, 1, 63};
      logic [31:0] w;
      if ($urandom_range(0, 15) == 0) return 32'h0;
      w = $urandom;
      w[31:26] = 6'(ops[$urandom_range(0, 23)]);
      if (w[31:26] == 6'h0) w[5:0] = 6'(fns[$urandom_range(0, 20)]);
      if ($urandom_range(0, 7) == 0) w[31:26] = 6'(6'h28 + 6'($urandom_range(0, 3)));
      return w;
   endfunction

   task automatic writeByte(int a, logic [7:0] d);
      bus.load_we = 1'b1;
      bus.load_addr = 9'(a);
      bus.load_data = d;
      @(posedge clk);
      refMem[a] = d;
      #1;
      bus.load_we = 1'b0;
   endtask

   task automatic writeWord(int a, logic [31:0] w);
      writeByte(a, w[31:24]);
      writeByte(a + 1, w[23:16]);
      writeByte(a + 2, w[15:8]);
      writeByte(a + 3, w[7:0]);
   endtask

   task automatic applyStimulus(int a);
      bus.addr = 9'(a);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string name, logic [31:0] expInstr, logic [14:0] expCtl);
      checks++;
      if (bus.instruction !== expInstr) begin
         failures++;
         $display("[TB] FAIL %s instruction: got %h expected %h", name, bus.instruction, expInstr);
      end
      checks++;
      if (bus.control_output !== expCtl) begin
         failures++;
         $display("[TB] FAIL %s control: got %h expected %h", name, bus.control_output, expCtl);
      end
   endtask

   typedef struct {
      logic [31:0] word;
      logic [14:0] ctl;
      string       name;
   } vec_t;

   vec_t vecs [$];

   initial begin
      logic [31:0] expI;
      logic [14:0] expC;
      int a;

      buildModel();
      vecs.push_back('{32'h8C220004, 15'h4641, "LW"});
      vecs.push_back('{32'h80220000, 15'h4609, "LB"});
      vecs.push_back('{32'hA0220004, 15'h4011, "SB"});
      vecs.push_back('{32'h10220003, 15'h0900, "BEQ"});
      vecs.push_back('{32'h0C000010, 15'h0380, "JAL"});
      vecs.push_back('{32'h00200011, 15'h0004, "MTHI"});
      vecs.push_back('{32'h00200013, 15'h0002, "MTLO"});
      vecs.push_back('{32'h00000000, 15'h0000, "NOP"});
      vecs.push_back('{32'hFC000000, 15'h0000, "badop"});
      vecs.push_back('{32'h00000001, 15'h0000, "badfunct"});
      vecs.push_back('{32'h3C011234, 15'h7A00, "LUI"});
      vecs.push_back('{32'h00021043, 15'h7A00, "SRA"});
      vecs.push_back('{32'h94220000, 15'h4621, "LHU"});
      vecs.push_back('{32'hAC220000, 15'h4051, "SW"});
      vecs.push_back('{32'h03E00008, 15'h0100, "JR"});
      vecs.push_back('{32'h0020F809, 15'h0300, "JALR"});
      vecs.push_back('{32'h04200003, 15'h0900, "BLTZ"});
      vecs.push_back('{32'h08000010, 15'h0180, "J"});
      vecs.push_back('{32'h34220005, 15'h5A00, "ORI"});
      vecs.push_back('{32'h2C220001, 15'h7200, "SLTIU"});
      vecs.push_back('{32'h00221827, 15'h2A00, "NOR"});
      vecs.push_back('{32'h00221822, 15'h0A00, "SUB"});

      // Reset held while the whole memory is cleared and word 0 is preloaded
      reset = 1'b1;
      bus.addr = '0;
      bus.load_we = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      for (int i = 0; i < 512; i++) writeByte(i, 8'h00);
      writeWord(0, 32'h00221821);
      checkOutput("reset_with_preload", 32'h0, 15'h0);

      reset = 1'b0;
      applyStimulus(0);
      checkOutput("first_after_reset", 32'h00221821, 15'h0200);

      for (int i = 0; i < vecs.size(); i++) begin
         a = 16 + 4 * i;
         writeWord(a, vecs[i].word);
         applyStimulus(a + (i % 4));
         checkOutput(vecs[i].name, vecs[i].word, vecs[i].ctl);
      end

      writeWord(32'h1FC, 32'hDEADBEEF);
      applyStimulus(32'h1FE);
      checkOutput("top_word_1FE", 32'hDEADBEEF, 15'h0);
      applyStimulus(32'h1FF);
      checkOutput("top_word_1FF", 32'hDEADBEEF, 15'h0);

      // Same-edge preload and fetch of word 0: old bytes first, new byte next cycle
      bus.addr = '0;
      bus.load_we = 1'b1;
      bus.load_addr = '0;
      bus.load_data = 8'h12;
      @(posedge clk);
      refMem[0] = 8'h12;
      #1;
      bus.load_we = 1'b0;
      checkOutput("read_before_write", 32'h00221821, 15'h0200);
      applyStimulus(0);
      checkOutput("after_write", 32'h12221821, 15'h0900);

      reset = 1'b1;
      applyStimulus(16);
      checkOutput("mid_run_reset", 32'h0, 15'h0);
      reset = 1'b0;
      applyStimulus(16);
      checkOutput("reset_release", 32'h8C220004, 15'h4641);

      for (int i = 0; i < 128; i++) writeWord(4 * i, genInstr());

      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 19) == 0);
         bus.addr = 9'($urandom_range(0, 511));
         bus.load_we = ($urandom_range(0, 3) == 0);
         bus.load_addr = 9'($urandom_range(0, 511));
         bus.load_data = 8'($urandom);
         expI = reset ? 32'h0 : refWord(int'(bus.addr));
         expC = reset ? 15'h0 : refCtl(refWord(int'(bus.addr)));
         @(posedge clk);
         if (bus.load_we) refMem[bus.load_addr] = bus.load_data;
         #1;
         checkOutput("random", expI, expC);
      end
      reset = 1'b0;
      bus.load_we = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/ppu_control_unit.md
Name: ppu_control_unit

Overview:
- Fetch-and-decode front end of the PPU MIPS pipeline.
- Holds a 512-byte, byte-addressed instruction memory and reads one 32-bit big-endian word per cycle at the supplied PC address.
- Decodes that word into a 15-bit control word consumed by the ID/EX/MEM/WB stages.
- Registers both the fetched instruction and the control word, so the block acts as the IF/ID boundary.

Parameters:
- MEM_BYTES, 512, instruction memory depth in bytes; address width is log2(MEM_BYTES) = 9.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  9  byte address of instruction to fetch (PC low bits).
- load_we  in  1  preload write enable for instruction memory.
- load_addr  in  9  preload byte address.
- load_data  in  8  preload byte.
- instruction  out  32  registered fetched word.
- control_output  out  15  registered control word.

Behaviour:
- Reset: at a clk edge with reset=1, instruction=0 and control_output=0. Memory contents are not cleared.
- Fetch: word address is {addr[8:2],2'b00}; addr[1:0] are ignored. The word is formed big-endian: mem[a]=bits 31:24 … mem[a+3]=bits 7:0.
- Latency: 1 cycle. At each non-reset edge, instruction<=word and control_output<=decode(word).
- Preload: at an edge with load_we=1, mem[load_addr]<=load_data. This happens even during reset.
- Read-before-write: a fetch of the same word in the same cycle returns the old byte.
- Control word bit map:
  - [14] shift_imm: operand B is immediate or shamt.
  - [13:11] alu_op.
  - [10] load_instr.
  - [9] rf_enable.
  - [8] branch.
  - [7] ta_instr: target address comes from the instruction field.
  - [6:5] mem_size: 00 byte, 01 half, 10 word.
  - [4] mem_rw: 1 = store.
  - [3] mem_se: sign-extend load.
  - [2] hi_enable.
  - [1] lo_enable.
  - [0] mem_enable.
- alu_op encodings: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 set-less-than, 111 pass-B (LUI and shifts).
- Decode, R-type (opcode 0):
  - ADDU/ADD, SUBU/SUB, AND, OR, XOR, NOR, SLT, SLTU: matching alu_op, rf_enable=1.
  - SLL, SRL, SRA: alu_op=111, shift_imm=1, rf_enable=1.
  - MFHI, MFLO: rf_enable=1.
  - MTHI: hi_enable=1. MTLO: lo_enable=1.
  - JR: branch=1. JALR: branch=1, rf_enable=1.
- Decode, I-type and J-type:
  - ADDI/ADDIU, SLTI/SLTIU, ANDI, ORI, XORI: shift_imm=1, matching alu_op, rf_enable=1.
  - LUI: shift_imm=1, alu_op=111, rf_enable=1.
  - LB, LH, LW: shift_imm=1, alu_op=000, load_instr=1, rf_enable=1, mem_enable=1, size per op; mem_se=1 for LB/LH.
  - LBU, LHU: as LB/LH but mem_se=0.
  - SB, SH, SW: shift_imm=1, alu_op=000, mem_rw=1, mem_enable=1, size per op.
  - BEQ, BNE, BLEZ, BGTZ, REGIMM (BLTZ/BGEZ): alu_op=001, branch=1.
  - J: branch=1, ta_instr=1. JAL: branch=1, ta_instr=1, rf_enable=1.
- The all-zero word (NOP) decodes to control 0. Any unrecognised opcode/funct also decodes to 0.
- Boundary conditions:
  - addr 0x1FF fetches bytes 0x1FC..0x1FF; no wrap is possible.
  - reset and load_we together: the preload write occurs and the outputs clear.
  - Deasserting reset: the first valid output appears one edge later.

Decomposition:
- Package ppu_pkg holds:
  - opcode and funct constants;
  - control-bit index constants (CTL_SHIFT_IMM=14 … CTL_MEM_EN=0);
  - ALU op encodings;
  - mem_size encodings.
- Sub-module instruction_memory: byte array, sync write port, combinational aligned big-endian 32-bit read.
- Decode is a combinational function inside ppu_control_unit, followed by the output registers.

Test Plan:
- Reset with mem preloaded with 0x00221821 at 0 → after reset edge both outputs are 0. Release reset, addr=0 → next edge instruction=0x00221821, control_output=0x0200.
- Preload LW 0x8C220004 at 4, addr=4 → control_output=0x4641. Preload LB 0x80220000 at 8, addr=8 → 0x4609.
- SB 0xA0220004 → 0x4011. BEQ 0x10220003 → 0x0900. JAL 0x0C000010 → 0x0380.
- MTHI 0x00200011 → 0x0004. MTLO 0x00200013 → 0x0002. NOP 0x00000000 → 0x0000. Unknown opcode 0xFC000000 → 0x0000.
- addr=0x1FE with word 0xDEADBEEF at 0x1FC → instruction=0xDEADBEEF (low bits ignored).
- Same-cycle preload of byte 0x12 at addr 0 while fetching addr 0 → old word returned; next cycle bits 31:24 = 0x12.
